// File: rtl/median_window_feeder_if.sv
// Pixel-stream and triplet handshake bundle for median_window_feeder.
// The master drives raster pixels; the slave returns vertical triplets.
interface median_window_feeder_if;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] in_data;
  logic       out_valid;
  logic [7:0] val_0;
  logic [7:0] val_1;
  logic [7:0] val_2;
  logic [9:0] out_col;
  logic       frame_done;

  modport master (
    output in_valid, in_sof, in_data,
    input  out_valid, val_0, val_1, val_2,
    input  out_col, frame_done
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output out_valid, val_0, val_1, val_2,
    output out_col, frame_done
  );
endinterface

// File: rtl/median_window_feeder.sv
// Two-line-buffer feeder producing vertical 3-pixel columns
// (rows r-2, r-1, r) for a downstream 3-input median unit.
module median_window_feeder #(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic clk,
  input  logic rst,
  median_window_feeder_if.slave bus
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [9:0] COL_MAX = 10'(IMG_W - 1);
  localparam logic [9:0] ROW_MAX = 10'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } state_t;

  state_t     state, state_n;
  logic [9:0] col, col_n;
  logic [9:0] row, row_n;
  logic       take;
  logic       emit;
  logic       last;
  logic [AW-1:0] wa;

  logic [7:0] lb0 [IMG_W];
  logic [7:0] lb1 [IMG_W];

  always_comb begin
    state_n = state;
    col_n   = col;
    row_n   = row;
    take    = 1'b0;
    emit    = 1'b0;
    last    = 1'b0;
    wa      = col[AW-1:0];
    if (bus.in_valid) begin
      if (bus.in_sof) begin
        // sof always restarts at (0,0), aborting any frame in flight
        take    = 1'b1;
        wa      = '0;
        col_n   = 10'd1;
        row_n   = '0;
        state_n = FILL;
      end else if (state != IDLE) begin
        take = 1'b1;
        emit = (state == STREAM);
        last = emit && row == ROW_MAX && col == COL_MAX;
        if (col == COL_MAX) begin
          col_n = '0;
          row_n = row + 10'd1;
        end else begin
          col_n = col + 10'd1;
        end
        if (state == FILL && row == 10'd1 && col == COL_MAX)
          state_n = STREAM;
        if (last) begin
          state_n = IDLE;
          row_n   = '0;
          col_n   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      col            <= '0;
      row            <= '0;
      bus.out_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.val_0      <= '0;
      bus.val_1      <= '0;
      bus.val_2      <= '0;
      bus.out_col    <= '0;
    end else begin
      state          <= state_n;
      col            <= col_n;
      row            <= row_n;
      bus.out_valid  <= emit;
      bus.frame_done <= last;
      if (take) begin
        bus.val_0   <= lb1[wa];
        bus.val_1   <= lb0[wa];
        bus.val_2   <= bus.in_data;
        bus.out_col <= bus.in_sof ? '0 : col;
      end
    end
  end

  // Line buffers carry no reset; rows 0-1 overwrite them before use
  always_ff @(posedge clk) begin
    if (!rst && take) begin
      lb1[wa] <= lb0[wa];
      lb0[wa] <= bus.in_data;
    end
  end

endmodule

// File: tb/tb_median_window_feeder.sv
// Randomized self-checking bench for median_window_feeder
// against a frame-array reference model (IMG_W=IMG_H=4).
module tb_median_window_feeder;

  localparam int W = 4;
  localparam int H = 4;

  logic clk;
  logic rst;
  median_window_feeder_if bus ();

  median_window_feeder #(
    .IMG_W(W),
    .IMG_H(H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  logic [7:0] img [H][W];
  bit         m_act;
  int         m_idx;
  logic       exp_v;
  logic       exp_fd;
  bit         exp_known;
  logic [7:0] exp_v0, exp_v1, exp_v2;
  logic [9:0] exp_col;

  function automatic logic [7:0] pix(int base, int i);
    return 8'(base + 16 * (i / W) + (i % W));
  endfunction

  // Drive one cycle, advance the reference model at the edge,
  // then leave outputs ready for sampling 1 time unit later.
  task automatic step(input logic v, input logic s,
                      input logic [7:0] d, input logic r);
    int rr, cc;
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.in_data  = d;
    rst          = r;
    @(posedge clk);
    exp_v  = 1'b0;
    exp_fd = 1'b0;
    if (r) begin
      m_act     = 0;
      exp_known = 1;
      exp_v0    = '0;
      exp_v1    = '0;
      exp_v2    = '0;
      exp_col   = '0;
    end else if (v && s) begin
      m_act     = 1;
      img[0][0] = d;
      m_idx     = 1;
      exp_known = 0;
    end else if (v && m_act) begin
      rr = m_idx / W;
      cc = m_idx % W;
      if (rr >= 2) begin
        exp_v     = 1'b1;
        exp_v0    = img[rr-2][cc];
        exp_v1    = img[rr-1][cc];
        exp_v2    = d;
        exp_col   = 10'(cc);
        exp_fd    = (m_idx == W * H - 1);
        exp_known = 1;
      end else begin
        exp_known = 0;
      end
      img[rr][cc] = d;
      m_idx++;
      if (m_idx == W * H) m_act = 0;
    end
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;
    rst          = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 8'h55, 1'b1);
    n_chk++;
    if ({bus.out_valid, bus.frame_done, bus.val_0, bus.val_1,
         bus.val_2, bus.out_col} !== 36'h0) begin
      $display("FAIL reset: got v=%b fd=%b vals=%h/%h/%h col=%0d, want all 0",
               bus.out_valid, bus.frame_done, bus.val_0, bus.val_1,
               bus.val_2, bus.out_col);
    end else n_pass++;
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, 1'b0, 8'($urandom), 1'b0);
      n_chk++;
      if (bus.out_valid !== exp_v || bus.frame_done !== exp_fd ||
          (exp_known && {bus.val_0, bus.val_1, bus.val_2, bus.out_col}
                        !== {exp_v0, exp_v1, exp_v2, exp_col})) begin
        $display("FAIL reset_sof_dropped px%0d: got v=%b vals=%h/%h/%h, want v=%b vals=%h/%h/%h",
                 i, bus.out_valid, bus.val_0, bus.val_1, bus.val_2,
                 exp_v, exp_v0, exp_v1, exp_v2);
      end else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int cnt = 0;
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, i == 0, pix(0, i), 1'b0);
      n_chk++;
      if (bus.out_valid !== exp_v || bus.frame_done !== exp_fd ||
          (exp_known && {bus.val_0, bus.val_1, bus.val_2, bus.out_col}
                        !== {exp_v0, exp_v1, exp_v2, exp_col})) begin
        $display("FAIL b2b px%0d: got v=%b fd=%b vals=%h/%h/%h col=%0d, want v=%b fd=%b vals=%h/%h/%h col=%0d",
                 i, bus.out_valid, bus.frame_done, bus.val_0, bus.val_1,
                 bus.val_2, bus.out_col, exp_v, exp_fd, exp_v0, exp_v1,
                 exp_v2, exp_col);
      end else n_pass++;
      if (bus.out_valid === 1'b1) cnt++;
      if (i == 8) begin
        n_chk++;
        if ({bus.out_valid, bus.val_0, bus.val_1, bus.val_2, bus.out_col}
            !== {1'b1, 8'h00, 8'h10, 8'h20, 10'd0}) begin
          $display("FAIL b2b_first: got v=%b %h/%h/%h col=%0d, want 1 00/10/20 col=0",
                   bus.out_valid, bus.val_0, bus.val_1, bus.val_2, bus.out_col);
        end else n_pass++;
      end
      if (i == 15) begin
        n_chk++;
        if ({bus.frame_done, bus.val_0, bus.val_1, bus.val_2, bus.out_col}
            !== {1'b1, 8'h13, 8'h23, 8'h33, 10'd3}) begin
          $display("FAIL b2b_last: got fd=%b %h/%h/%h col=%0d, want 1 13/23/33 col=3",
                   bus.frame_done, bus.val_0, bus.val_1, bus.val_2, bus.out_col);
        end else n_pass++;
      end
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.frame_done !== 1'b0 || cnt != 8) begin
      $display("FAIL b2b_count: got count=%0d v=%b fd=%b, want count=8 v=0 fd=0",
               cnt, bus.out_valid, bus.frame_done);
    end else n_pass++;
  endtask

  task automatic test_gap();
    int cnt = 0;
    for (int i = 0; i < W * H; i++) begin
      for (int g = 0; g < 2; g++) begin
        if (g == 0) step(1'b1, i == 0, pix(0, i), 1'b0);
        else        step(1'b0, 1'b0, 8'($urandom), 1'b0);
        n_chk++;
        if (bus.out_valid !== exp_v || bus.frame_done !== exp_fd ||
            (exp_known && {bus.val_0, bus.val_1, bus.val_2, bus.out_col}
                          !== {exp_v0, exp_v1, exp_v2, exp_col})) begin
          $display("FAIL gap px%0d g%0d: got v=%b fd=%b vals=%h/%h/%h col=%0d, want v=%b fd=%b vals=%h/%h/%h col=%0d",
                   i, g, bus.out_valid, bus.frame_done, bus.val_0, bus.val_1,
                   bus.val_2, bus.out_col, exp_v, exp_fd, exp_v0, exp_v1,
                   exp_v2, exp_col);
        end else n_pass++;
        if (bus.out_valid === 1'b1) cnt++;
      end
    end
    n_chk++;
    if (cnt != 8) $display("FAIL gap_count: got %0d, want 8", cnt);
    else n_pass++;
  endtask

  task automatic test_no_sof();
    int cnt = 0;
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, 1'b0, pix(0, i), 1'b0);
      if (bus.out_valid === 1'b1) cnt++;
    end
    n_chk++;
    if (cnt != 0) $display("FAIL no_sof: got %0d triplets, want 0", cnt);
    else n_pass++;
    test_back_to_back();
  endtask

  task automatic test_abort();
    int cnt = 0;
    int fd  = 0;
    for (int i = 0; i < 10; i++) step(1'b1, i == 0, pix(0, i), 1'b0);
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, i == 0, pix(8'h80, i), 1'b0);
      n_chk++;
      if (bus.out_valid !== exp_v || bus.frame_done !== exp_fd ||
          (exp_known && {bus.val_0, bus.val_1, bus.val_2, bus.out_col}
                        !== {exp_v0, exp_v1, exp_v2, exp_col})) begin
        $display("FAIL abort px%0d: got v=%b fd=%b vals=%h/%h/%h col=%0d, want v=%b fd=%b vals=%h/%h/%h col=%0d",
                 i, bus.out_valid, bus.frame_done, bus.val_0, bus.val_1,
                 bus.val_2, bus.out_col, exp_v, exp_fd, exp_v0, exp_v1,
                 exp_v2, exp_col);
      end else n_pass++;
      if (bus.out_valid === 1'b1) cnt++;
      if (bus.frame_done === 1'b1) fd++;
    end
    n_chk++;
    if (cnt != 8 || fd != 1)
      $display("FAIL abort_count: got %0d triplets %0d done, want 8 and 1", cnt, fd);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    for (int i = 0; i < 13; i++) step(1'b1, i == 0, pix(0, i), 1'b0);
    step(1'b1, 1'b0, pix(0, 13), 1'b1);
    n_chk++;
    if ({bus.out_valid, bus.frame_done, bus.val_0, bus.val_1, bus.val_2}
        !== 26'h0) begin
      $display("FAIL reset_mid: got v=%b fd=%b vals=%h/%h/%h, want 0 0 00/00/00",
               bus.out_valid, bus.frame_done, bus.val_0, bus.val_1, bus.val_2);
    end else n_pass++;
    for (int i = 14; i < W * H; i++) begin
      step(1'b1, 1'b0, pix(0, i), 1'b0);
      if (bus.out_valid !== 1'b0 || bus.frame_done !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL reset_mid_tail: got %0d outputs, want 0", bad);
    else n_pass++;
    test_back_to_back();
  endtask

  task automatic test_two_frames();
    int cnt = 0;
    int fd  = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < W * H; i++) begin
        step(1'b1, i == 0, 8'($urandom), 1'b0);
        n_chk++;
        if (bus.out_valid !== exp_v || bus.frame_done !== exp_fd ||
            (exp_known && {bus.val_0, bus.val_1, bus.val_2, bus.out_col}
                          !== {exp_v0, exp_v1, exp_v2, exp_col})) begin
          $display("FAIL two_frames f%0d px%0d: got v=%b fd=%b vals=%h/%h/%h, want v=%b fd=%b vals=%h/%h/%h",
                   f, i, bus.out_valid, bus.frame_done, bus.val_0, bus.val_1,
                   bus.val_2, exp_v, exp_fd, exp_v0, exp_v1, exp_v2);
        end else n_pass++;
        if (bus.out_valid === 1'b1) cnt++;
        if (bus.frame_done === 1'b1) fd++;
      end
    end
    n_chk++;
    if (cnt != 16 || fd != 2)
      $display("FAIL two_frames_count: got %0d triplets %0d done, want 16 and 2", cnt, fd);
    else n_pass++;
  endtask

  task automatic test_random();
    logic v, s, r;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = (!m_act && $urandom_range(0, 3) == 0) || ($urandom_range(0, 59) == 0);
      r = ($urandom_range(0, 199) == 0);
      step(v, s, 8'($urandom), r);
      n_chk++;
      if (bus.out_valid !== exp_v || bus.frame_done !== exp_fd ||
          (exp_known && {bus.val_0, bus.val_1, bus.val_2, bus.out_col}
                        !== {exp_v0, exp_v1, exp_v2, exp_col})) begin
        $display("FAIL random cyc%0d: got v=%b fd=%b vals=%h/%h/%h col=%0d, want v=%b fd=%b vals=%h/%h/%h col=%0d",
                 i, bus.out_valid, bus.frame_done, bus.val_0, bus.val_1,
                 bus.val_2, bus.out_col, exp_v, exp_fd, exp_v0, exp_v1,
                 exp_v2, exp_col);
      end else n_pass++;
    end
  endtask

  initial begin
    clk          = 1'b0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;
    n_chk        = 0;
    n_pass       = 0;
    m_act        = 0;
    m_idx        = 0;
    exp_known    = 0;
    #2;
    test_reset();
    test_back_to_back();
    test_gap();
    test_no_sof();
    test_abort();
    test_reset_mid();
    test_two_frames();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
